// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol/data widths, control tokens, align FSM states.
// Pure declarations, no logic.
// Used by both the receive aligner/decoder and the transmit-side encoder.
package tmds_pkg;

  localparam int SYM_W = 10;
  localparam int DAT_W = 8;

  // Control tokens as 10-bit symbols, bit 0 is the first bit on the wire.
  localparam logic [SYM_W-1:0] TOK_C00 = 10'h354;
  localparam logic [SYM_W-1:0] TOK_C01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK_C10 = 10'h154;
  localparam logic [SYM_W-1:0] TOK_C11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_t;

  // Largest of three timing parameters; sizes the shared alignment counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tmds_rx_align_decode_if.sv
// Bundle of the per-channel receive data path: raw deserialized word in,
// decoded pixel/control/status out. master = word source / consumer side,
// slave = the aligner/decoder.
interface tmds_rx_align_decode_if;
  import tmds_pkg::*;

  logic [SYM_W-1:0] i_raw;
  logic [DAT_W-1:0] o_data;
  logic [1:0]       o_ctrl;
  logic             o_de;
  logic             o_locked;
  logic [3:0]       o_offset;

  modport master (
    output i_raw,
    input  o_data, o_ctrl, o_de, o_locked, o_offset
  );

  modport slave (
    input  i_raw,
    output o_data, o_ctrl, o_de, o_locked, o_offset
  );

endinterface

// File: rtl/tmds_decode_10to8.sv
// Combinational TMDS symbol decoder: 10b symbol -> {is_token, de, ctrl, data}.
// Latency: 0 cycles (pure combinational).
// No flow control; evaluates every cycle.
module tmds_decode_10to8
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output logic             is_token,
  output logic             de,
  output logic [1:0]       ctrl,
  output logic [DAT_W-1:0] data
);

  logic [DAT_W-1:0] t;

  // Token match, then undo the inversion and XOR/XNOR transition coding.
  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    unique case (sym)
      TOK_C00: ctrl = 2'b00;
      TOK_C01: ctrl = 2'b01;
      TOK_C10: ctrl = 2'b10;
      TOK_C11: ctrl = 2'b11;
      default: is_token = 1'b0;
    endcase
    de = ~is_token;

    t       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = t[0];
    for (int i = 1; i < DAT_W; i++) begin
      data[i] = sym[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

endmodule

// File: rtl/tmds_rx_align_decode.sv
// One TMDS channel receiver: barrel-window symbol alignment on control tokens + 10b->8b decode.
// Latency: 3 cycles from a word on i_raw to decoded outputs (offset 0).
// No backpressure: one word accepted and one result produced every pixel clock.
module tmds_rx_align_decode
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = 8,     // tokens in a row at one offset to lock, at least 2
  parameter int SEARCH_TIMEOUT = 2048,  // token-free cycles before trying the next offset
  parameter int LOSS_TIMEOUT   = 4096   // token-free cycles while locked before dropping lock
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  tmds_rx_align_decode_if.slave rx
);

  localparam int CNT_W = $clog2(max3(TOKEN_RUN, SEARCH_TIMEOUT, LOSS_TIMEOUT));
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(TOKEN_RUN - 1);
  localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_TIMEOUT - 1);

  align_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       offset_q, offset_d;
  logic             skip_q, skip_d;

  logic [SYM_W-1:0]   raw_q;
  logic [SYM_W-1:0]   sym_q;
  logic [2*SYM_W-1:0] window;
  logic [SYM_W-1:0]   aligned;

  logic             dec_token;
  logic             dec_de;
  logic [1:0]       dec_ctrl;
  logic [DAT_W-1:0] dec_data;

  logic [DAT_W-1:0] data_q;
  logic [1:0]       ctrl_q;
  logic             de_q;
  logic             locked_q;

  // Two consecutive words cover every possible symbol boundary; offset picks one.
  assign window  = {rx.i_raw, raw_q};
  assign aligned = window[offset_q +: SYM_W];

  // Input word history and aligned symbol register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      raw_q <= '0;
      sym_q <= '0;
    end else begin
      raw_q <= rx.i_raw;
      sym_q <= aligned;
    end
  end

  tmds_decode_10to8 u_dec (
    .sym      (sym_q),
    .is_token (dec_token),
    .de       (dec_de),
    .ctrl     (dec_ctrl),
    .data     (dec_data)
  );

  // Alignment FSM state, shared counter, offset and post-shift skip flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_SEARCH;
      cnt_q    <= '0;
      offset_q <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      skip_q   <= skip_d;
    end
  end

  // Next-state logic. The symbol just after an offset shift was captured with
  // the old offset, so SEARCH ignores it and holds the counter for that cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    skip_d   = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        if (skip_q) begin
          cnt_d = cnt_q;
        end else if (dec_token) begin
          state_d = ST_VERIFY;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == SEARCH_LAST) begin
          cnt_d    = '0;
          offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          skip_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_VERIFY: begin
        if (!dec_token) begin
          state_d = ST_SEARCH;
          cnt_d   = '0;
        end else if (cnt_q == RUN_LAST) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (dec_token) begin
          cnt_d = '0;
        end else if (cnt_q == LOSS_LAST) begin
          state_d = ST_SEARCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SEARCH;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register keyed on the next state so lock status and decoded
  // fields change together; control is held across data symbols.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      locked_q <= 1'b0;
      de_q     <= 1'b0;
      ctrl_q   <= '0;
      data_q   <= '0;
    end else begin
      locked_q <= (state_d == ST_LOCKED);
      if (state_d != ST_LOCKED) begin
        de_q   <= 1'b0;
        ctrl_q <= '0;
        data_q <= '0;
      end else if (dec_token) begin
        de_q   <= 1'b0;
        ctrl_q <= dec_ctrl;
        data_q <= '0;
      end else begin
        de_q   <= dec_de;
        data_q <= dec_data;
      end
    end
  end

  assign rx.o_data   = data_q;
  assign rx.o_ctrl   = ctrl_q;
  assign rx.o_de     = de_q;
  assign rx.o_locked = locked_q;
  assign rx.o_offset = offset_q;

endmodule

// File: tb/tb_tmds_rx_align_decode.sv
// Directed bench for the TMDS receive aligner/decoder.
// Builds a serial symbol stream, chops it into words at a chosen bit phase,
// and checks lock, offset, decode, loss and reset behaviour.
module tb_tmds_rx_align_decode;

  localparam int RUN  = 8;
  localparam int STO  = 64;
  localparam int LTO  = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  int         phase = 0;
  logic [9:0] prev_sym = 10'h000;

  tmds_rx_align_decode_if bus ();

  tmds_rx_align_decode #(
    .TOKEN_RUN      (RUN),
    .SEARCH_TIMEOUT (STO),
    .LOSS_TIMEOUT   (LTO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  // Word bit j carries serial bit (j - phase); symbols start at bit 'phase'.
  function automatic logic [9:0] mk_word(input logic [9:0] prv, input logic [9:0] cur, input int p);
    logic [19:0] w;
    w = {cur, prv};
    w = w >> (10 - p);
    return w[9:0];
  endfunction

  task automatic send(input logic [9:0] s);
    bus.i_raw = mk_word(prev_sym, s, phase);
    prev_sym  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send(prev_sym);
    rst = 1'b0;
  endtask

  task automatic wait_lock(input logic [9:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.o_locked !== 1'b1 && n < budget) begin
      send(s);
      n++;
    end
    n_vec++;
    if (bus.o_locked !== 1'b1) begin
      n_err++;
      $display("FAIL %s_lock: locked=%b after %0d cycles, required 1 within %0d", tag, bus.o_locked, n, budget);
    end
  endtask

  task automatic test_reset();
    phase    = 0;
    prev_sym = 10'h000;
    bus.i_raw = 10'h000;
    do_reset();
    n_vec++;
    if (bus.o_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", bus.o_locked); end
    n_vec++;
    if (bus.o_offset !== 4'd0) begin n_err++; $display("FAIL reset_offset: got %0d want 0", bus.o_offset); end
    n_vec++;
    if ({bus.o_de, bus.o_ctrl, bus.o_data} !== 11'd0)
      begin n_err++; $display("FAIL reset_outs: de=%b ctrl=%b data=%h want all 0", bus.o_de, bus.o_ctrl, bus.o_data); end
  endtask

  task automatic test_lock_phase3();
    phase    = 3;
    prev_sym = 10'h354;
    do_reset();
    wait_lock(10'h354, 3 * STO + RUN + 4, "ph3");
    n_vec++;
    if (bus.o_offset !== 4'd3) begin n_err++; $display("FAIL ph3_offset: got %0d want 3", bus.o_offset); end
    n_vec++;
    if (bus.o_ctrl !== 2'b00) begin n_err++; $display("FAIL ph3_ctrl: got %b want 00", bus.o_ctrl); end
    n_vec++;
    if (bus.o_de !== 1'b0) begin n_err++; $display("FAIL ph3_de: got %b want 0", bus.o_de); end
  endtask

  task automatic test_all_phases();
    for (int p = 0; p < 10; p++) begin
      phase    = p;
      prev_sym = 10'h2AB;
      do_reset();
      wait_lock(10'h2AB, p * (STO + 1) + RUN + 8, $sformatf("phase%0d", p));
      n_vec++;
      if (bus.o_offset !== 4'(p))
        begin n_err++; $display("FAIL phase%0d_offset: got %0d want %0d", p, bus.o_offset, p); end
      n_vec++;
      if (bus.o_ctrl !== 2'b11)
        begin n_err++; $display("FAIL phase%0d_ctrl: got %b want 11", p, bus.o_ctrl); end
    end
  endtask

  // Runs on the phase-9 lock left by the sweep; ctrl 11 must persist over data.
  task automatic test_data_decode();
    logic [9:0] syms [5] = '{10'h100, 10'h2FF, 10'h154, 10'h2AB, 10'h2AB};
    logic       e_de [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] e_dat[3] = '{8'h00, 8'hFE, 8'h00};
    logic [1:0] e_ctl[3] = '{2'b11, 2'b11, 2'b10};
    for (int i = 0; i < 5; i++) begin
      send(syms[i]);
      if (i >= 2) begin
        n_vec++;
        if ({bus.o_locked, bus.o_de, bus.o_ctrl, bus.o_data} !== {1'b1, e_de[i-2], e_ctl[i-2], e_dat[i-2]})
          begin
            n_err++;
            $display("FAIL data_sym%0d: locked=%b de=%b ctrl=%b data=%h want locked=1 de=%b ctrl=%b data=%h",
                     i - 2, bus.o_locked, bus.o_de, bus.o_ctrl, bus.o_data, e_de[i-2], e_ctl[i-2], e_dat[i-2]);
          end
      end
    end
  endtask

  task automatic test_verify_abort();
    int n;
    phase    = 5;
    prev_sym = 10'h100;
    do_reset();
    n = 0;
    while (bus.o_offset !== 4'd5 && n < 6 * (STO + 1)) begin
      send(10'h100);
      n++;
    end
    n_vec++;
    if (bus.o_offset !== 4'd5) begin n_err++; $display("FAIL abort_reach5: offset=%0d want 5", bus.o_offset); end
    for (int i = 0; i < 3; i++) send(10'h354);
    for (int i = 0; i < 3; i++) send(10'h100);
    n_vec++;
    if ({bus.o_locked, bus.o_offset} !== {1'b0, 4'd5})
      begin n_err++; $display("FAIL abort_state: locked=%b offset=%0d want locked=0 offset=5", bus.o_locked, bus.o_offset); end
    for (int i = 0; i < 8; i++) send(10'h354);
    send(10'h100);
    n_vec++;
    if (bus.o_locked !== 1'b0) begin n_err++; $display("FAIL abort_early_lock: locked=%b want 0 after 7 tokens", bus.o_locked); end
    send(10'h100);
    n_vec++;
    if ({bus.o_locked, bus.o_offset, bus.o_ctrl} !== {1'b1, 4'd5, 2'b00})
      begin n_err++; $display("FAIL abort_relock: locked=%b offset=%0d ctrl=%b want 1/5/00", bus.o_locked, bus.o_offset, bus.o_ctrl); end
  endtask

  // Last token's output appears at iteration 5; lock must fall at 5+LTO.
  task automatic test_loss();
    for (int i = 0; i < 4; i++) send(10'h354);
    for (int it = 4; it <= 5 + LTO; it++) begin
      send(10'h100);
      if (it == 6) begin
        n_vec++;
        if ({bus.o_de, bus.o_data} !== {1'b1, 8'h00})
          begin n_err++; $display("FAIL loss_data: de=%b data=%h want 1/00", bus.o_de, bus.o_data); end
      end
      if (it == 4 + LTO) begin
        n_vec++;
        if (bus.o_locked !== 1'b1) begin n_err++; $display("FAIL loss_early: locked=%b want 1 one cycle before timeout", bus.o_locked); end
      end
      if (it == 5 + LTO) begin
        n_vec++;
        if ({bus.o_locked, bus.o_offset} !== {1'b0, 4'd5})
          begin n_err++; $display("FAIL loss_drop: locked=%b offset=%0d want 0/5", bus.o_locked, bus.o_offset); end
      end
    end
  endtask

  task automatic test_reset_midlock();
    phase    = 7;
    prev_sym = 10'h354;
    do_reset();
    wait_lock(10'h354, 8 * (STO + 1) + RUN + 8, "ph7");
    send(10'h2FF);
    send(10'h354);
    send(10'h354);
    n_vec++;
    if ({bus.o_locked, bus.o_de, bus.o_data} !== {1'b1, 1'b1, 8'hFE})
      begin n_err++; $display("FAIL midlock_pre: locked=%b de=%b data=%h want 1/1/FE", bus.o_locked, bus.o_de, bus.o_data); end
    rst = 1'b1;
    send(10'h354);
    rst = 1'b0;
    n_vec++;
    if ({bus.o_locked, bus.o_offset, bus.o_de, bus.o_data, bus.o_ctrl} !== 17'd0)
      begin
        n_err++;
        $display("FAIL midlock_rst: locked=%b offset=%0d de=%b data=%h ctrl=%b want all 0",
                 bus.o_locked, bus.o_offset, bus.o_de, bus.o_data, bus.o_ctrl);
      end
    wait_lock(10'h354, 8 * (STO + 1) + RUN + 8, "relock7");
    n_vec++;
    if (bus.o_offset !== 4'd7) begin n_err++; $display("FAIL relock7_offset: got %0d want 7", bus.o_offset); end
  endtask

  initial begin
    bus.i_raw = 10'h000;
    test_reset();
    test_lock_phase3();
    test_all_phases();
    test_data_decode();
    test_verify_abort();
    test_loss();
    test_reset_midlock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
